// File: rtl/evo_logic_cell.sv
// rtl/evo_logic_cell.sv - evolvable K-input LUT cell with side router and serial config
//
// Ports:
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   in, out      neighbour inputs / routed outputs, bit i belongs to side i
//   cfg_en       shift enable for the serial config chain
//   cfg_din      serial config bit, LSB-first
//   cfg_dout     chain pass-through to the next cell (shadow bit 0)
//   cfg_commit   request to copy the shadow register into the active config
//   cfg_full     a full config word has been shifted since the last commit/reset
//   cfg_err      sticky flag: a commit was rejected
module evo_logic_cell #(
  parameter int LUT_K = 4,
  parameter int N_IN  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_IN-1:0] in,
  output logic [N_IN-1:0] out,
  input  logic            cfg_en,
  input  logic            cfg_din,
  output logic            cfg_dout,
  input  logic            cfg_commit,
  output logic            cfg_full,
  output logic            cfg_err
);

  localparam int SEL_W    = $clog2(N_IN);
  localparam int LUT_N    = 1 << LUT_K;
  localparam int ISEL_LSB = LUT_N;
  localparam int OSEL_LSB = LUT_N + LUT_K * SEL_W;
  localparam int CFG_W    = OSEL_LSB + N_IN * SEL_W + 1;
  localparam int CNT_W    = $clog2(CFG_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CFG_W);

  logic [CFG_W-1:0] shadow_q, shadow_d;
  logic [CFG_W-1:0] active_q, active_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             lut_q, lut_d;

  logic [LUT_N-1:0] lut_bits;
  logic [LUT_K-1:0] lut_addr;
  logic             lut_comb;
  logic             lut_out;
  logic             reg_mode;

  assign cfg_dout = shadow_q[0];
  assign cfg_full = (cnt_q == CNT_MAX);
  assign cfg_err  = err_q;

  // Config loading. A commit is honoured only with a complete word and no
  // shift in the same cycle; a rejected commit leaves the shift/count alone.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    if (cfg_en) begin
      shadow_d = {cfg_din, shadow_q[CFG_W-1:1]};
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
    end
    if (cfg_commit) begin
      if (cfg_full && !cfg_en) begin
        active_d = shadow_q;
        cnt_d    = '0;
        err_d    = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  assign lut_bits = active_q[LUT_N-1:0];
  assign reg_mode = active_q[CFG_W-1];

  // LUT address: out-of-range input selectors contribute a constant 0.
  always_comb begin
    logic [SEL_W-1:0] isel;
    lut_addr = '0;
    for (int j = 0; j < LUT_K; j++) begin
      isel = active_q[ISEL_LSB + j*SEL_W +: SEL_W];
      if (32'(isel) < N_IN) lut_addr[j] = in[isel];
    end
  end

  assign lut_comb = lut_bits[lut_addr];
  assign lut_d    = lut_comb;
  assign lut_out  = reg_mode ? lut_q : lut_comb;

  // Router: selector m picks the m-th lowest input with the cell's own side
  // skipped, so a side can never echo its own input back.
  always_comb begin
    logic [SEL_W-1:0] osel;
    logic [SEL_W-1:0] src;
    out = '0;
    for (int i = 0; i < N_IN; i++) begin
      osel = active_q[OSEL_LSB + i*SEL_W +: SEL_W];
      src  = osel;
      if (osel == '0) begin
        out[i] = lut_out;
      end else if (32'(osel) < N_IN) begin
        if (32'(osel) - 1 < i) src = osel - SEL_W'(1);
        out[i] = in[src];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      active_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      lut_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      lut_q    <= lut_d;
    end
  end

endmodule

// File: tb/tb_evo_logic_cell.sv
// tb/tb_evo_logic_cell.sv - self-checking bench for evo_logic_cell
module tb_evo_logic_cell;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] in;
  logic [3:0] out;
  logic       cfg_en, cfg_din, cfg_dout, cfg_commit, cfg_full, cfg_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] in;
    logic [3:0] out;
  } vec_t;

  vec_t tbl[6];

  evo_logic_cell dut (
    .clk(clk), .rst_n(rst_n), .in(in), .out(out),
    .cfg_en(cfg_en), .cfg_din(cfg_din), .cfg_dout(cfg_dout),
    .cfg_commit(cfg_commit), .cfg_full(cfg_full), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [32:0] mk_cfg(input logic [15:0] lut, input logic [7:0] isel,
                                         input logic [7:0] osel, input logic rm);
    return {rm, osel, isel, lut};
  endfunction

  // Shift bits lo..hi of v, LSB first; inputs change 1 time unit after edges.
  task automatic shift_bits(input logic [32:0] v, input int lo, input int hi);
    for (int k = lo; k <= hi; k++) begin
      cfg_en  = 1'b1;
      cfg_din = v[k];
      @(posedge clk); #1;
    end
    cfg_en  = 1'b0;
    cfg_din = 1'b0;
  endtask

  task automatic do_commit();
    cfg_commit = 1'b1;
    @(posedge clk); #1;
    cfg_commit = 1'b0;
  endtask

  logic [32:0] cfg_and, cfg_b, cfg_c;
  logic [65:0] emitted;

  initial begin
    cfg_and = mk_cfg(16'h8000, 8'hE4, 8'h00, 1'b0);
    cfg_b   = mk_cfg(16'h0001, 8'hE4, 8'h00, 1'b0);
    cfg_c   = mk_cfg(16'hFFFF, 8'hE4, 8'h80, 1'b1);
    tbl[0] = '{4'b0000, 4'b0000};
    tbl[1] = '{4'b1111, 4'b1111};
    tbl[2] = '{4'b0111, 4'b0000};
    tbl[3] = '{4'b1110, 4'b0000};
    tbl[4] = '{4'b1011, 4'b0000};
    tbl[5] = '{4'b1111, 4'b1111};

    rst_n = 1'b0; in = 4'b0000;
    cfg_en = 1'b0; cfg_din = 1'b0; cfg_commit = 1'b0;
    @(posedge clk); #1;

    // Reset state under several input patterns
    in = 4'b1111; #1;
    check("reset_out_1111", out, 0);
    in = 4'b1010; #1;
    check("reset_out_1010", out, 0);
    check("reset_full", cfg_full, 0);
    check("reset_err", cfg_err, 0);
    check("reset_dout", cfg_dout, 0);
    rst_n = 1'b1;

    // 4-input AND config
    in = 4'b1111;
    shift_bits(cfg_and, 0, 32);
    check("and_full_before_commit", cfg_full, 1);
    check("and_out_before_commit", out, 4'b0000);
    do_commit();
    check("and_full_after_commit", cfg_full, 0);
    check("and_err_after_commit", cfg_err, 0);
    check("and_out_after_commit", out, 4'b1111);
    for (int v = 0; v < 6; v++) begin
      in = tbl[v].in; #1;
      check($sformatf("and_vec%0d", v), out, tbl[v].out);
      @(posedge clk); #1;
    end

    // Short commit rejected, then completed
    in = 4'b0000; #1;
    shift_bits(cfg_b, 0, 31);
    check("short_full", cfg_full, 0);
    do_commit();
    check("short_err", cfg_err, 1);
    check("short_out_unchanged", out, 4'b0000);
    shift_bits(cfg_b, 32, 32);
    check("short_full_after_last", cfg_full, 1);
    do_commit();
    check("short_err_cleared", cfg_err, 0);
    check("short_new_cfg_out", out, 4'b1111);

    // Registered LUT plus passthrough on side S
    in = 4'b1111; #1;
    shift_bits(cfg_c, 0, 32);
    check("reg_out_during_load", out, 4'b0000);
    do_commit();
    check("reg_out_commit_cycle", out, 4'b1000);
    @(posedge clk); #1;
    check("reg_out_next_cycle", out, 4'b1111);
    in = 4'b1101; #1;
    check("reg_out_passthrough", out, 4'b0111);

    // 66-bit chain pass-through: old shadow bits then 33 ones
    for (int k = 0; k < 66; k++) begin
      cfg_en  = 1'b1;
      cfg_din = (k < 33);
      #1;
      emitted[k] = cfg_dout;
      @(posedge clk); #1;
    end
    cfg_en = 1'b0; cfg_din = 1'b0;
    check("chain_dout_stream", emitted, {33'h1_FFFF_FFFF, cfg_c});
    check("chain_full", cfg_full, 1);
    do_commit();
    check("chain_zero_out", out, 4'b0000);
    check("chain_err", cfg_err, 0);

    // Commit together with a shift is rejected, count stays saturated
    in = 4'b1111; #1;
    shift_bits(cfg_and, 0, 32);
    cfg_en = 1'b1; cfg_din = 1'b0; cfg_commit = 1'b1;
    @(posedge clk); #1;
    cfg_en = 1'b0; cfg_commit = 1'b0;
    check("shift_commit_err", cfg_err, 1);
    check("shift_commit_full", cfg_full, 1);
    check("shift_commit_out", out, 4'b0000);

    // Asynchronous reset mid-shift discards partial configuration
    cfg_en = 1'b1; cfg_din = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("midreset_full", cfg_full, 0);
    check("midreset_err", cfg_err, 0);
    check("midreset_out", out, 4'b0000);
    check("midreset_dout", cfg_dout, 0);
    cfg_en = 1'b0; cfg_din = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    shift_bits(cfg_and, 0, 31);
    do_commit();
    check("midreset_short_err", cfg_err, 1);
    check("midreset_short_out", out, 4'b0000);
    shift_bits(cfg_and, 32, 32);
    do_commit();
    check("midreset_final_err", cfg_err, 0);
    check("midreset_final_out", out, 4'b1111);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
